// File: rtl/dequant_pkg.sv
// Shared definitions for the H.264 inverse-quantisation pipeline.
// Holds the dequant mode encodings, the init FSM states, the 6x3 base
// level-scale constants, the lane-to-scale-class mapping and the helper
// that builds one packed scale-table entry for a given QP.
// No ports: this is a package imported by dequant_pipe and
// dequant_scale_table.
package dequant_pkg;

  typedef enum logic [1:0] {
    MODE_AC        = 2'd0,
    MODE_LUMA_DC   = 2'd1,
    MODE_CHROMA_DC = 2'd2,
    MODE_AC_DC     = 2'd3
  } mode_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } init_state_e;

  typedef enum logic [1:0] {
    CLS_V0 = 2'd0,
    CLS_V1 = 2'd1,
    CLS_V2 = 2'd2
  } lane_class_e;

  localparam int SCALE_W = 13;
  localparam int ENTRY_W = 3 * SCALE_W;

  // Base scales indexed by QP%6, columns are v0, v1, v2.
  localparam logic [SCALE_W-1:0] BASE_SCALE [6][3] = '{
    '{13'd10, 13'd13, 13'd16},
    '{13'd11, 13'd14, 13'd18},
    '{13'd13, 13'd16, 13'd20},
    '{13'd14, 13'd18, 13'd23},
    '{13'd16, 13'd20, 13'd25},
    '{13'd18, 13'd23, 13'd29}
  };

  // Row r = lane/4, column c = lane%4: both even -> v0, both odd -> v2,
  // mixed parity -> v1.
  function automatic lane_class_e lane_class(input logic [3:0] lane);
    if (!lane[2] && !lane[0]) return CLS_V0;
    if (lane[2] && lane[0])   return CLS_V2;
    return CLS_V1;
  endfunction

  // Packed entry {v2,v1,v0}, each field shifted left by QP/6.
  function automatic logic [ENTRY_W-1:0] scale_entry(input logic [5:0] q);
    logic [2:0] rem;
    logic [5:0] shift;
    rem   = 3'(q % 6'd6);
    shift = q / 6'd6;
    return {BASE_SCALE[rem][2] << shift,
            BASE_SCALE[rem][1] << shift,
            BASE_SCALE[rem][0] << shift};
  endfunction

endpackage

// File: rtl/dequant_scale_table.sv
// 64-entry by 39-bit synchronous RAM holding the level-scale table.
// Ports:
//   clk      - clock
//   wr       - write enable, wr_addr/data_in written on the rising edge
//   wr_addr  - write address (QP)
//   rd_en    - read enable; data_out holds its last value when low
//   rd_addr  - read address (clamped QP)
//   data_in  - packed entry {v2,v1,v0}
//   data_out - registered read data
module dequant_scale_table
  import dequant_pkg::*;
(
  input  logic               clk,
  input  logic               wr,
  input  logic [5:0]         wr_addr,
  input  logic               rd_en,
  input  logic [5:0]         rd_addr,
  input  logic [ENTRY_W-1:0] data_in,
  output logic [ENTRY_W-1:0] data_out
);

  logic [ENTRY_W-1:0] r_mem [64];

  // Plain write port plus a read register that only loads on rd_en, so
  // the scale presented to stage 2 survives a pipeline stall.
  always_ff @(posedge clk) begin
    if (wr) r_mem[wr_addr] <= data_in;
    if (rd_en) data_out <= r_mem[rd_addr];
  end

endmodule

// File: rtl/dequant_pipe.sv
// Three-stage inverse-quantisation pipeline for 4x4 H.264 residual blocks.
// After reset an init FSM fills the scale table (one QP per cycle), then
// beats flow S1 (capture + table read), S2 (multiply), S3 (round/shift,
// saturate). All stages advance together when the output slot is free.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - input handshake (in_ready low until init_done)
//   in_mode, in_qp, in_dc - dequant mode, QP (clamped to QP_MAX), DC value
//   in_coeff              - 16 packed signed coefficients, lane i at i*COEFF_W
//   out_valid / out_ready - output handshake
//   out_coeff             - 16 packed saturated results, lane i at i*OUT_W
//   out_sat               - some lane of this beat clipped
//   init_done             - scale table fully loaded
module dequant_pipe
  import dequant_pkg::*;
#(
  parameter int COEFF_W = 12,
  parameter int OUT_W   = 16,
  parameter int DC_W    = 16,
  parameter int QP_MAX  = 51
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [5:0]           in_qp,
  input  logic [DC_W-1:0]      in_dc,
  input  logic [16*COEFF_W-1:0] in_coeff,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*OUT_W-1:0]  out_coeff,
  output logic                 out_sat,
  output logic                 init_done
);

  localparam int PROD_W = COEFF_W + 14;
  localparam int EXT_W  = (DC_W > PROD_W) ? DC_W + 1 : PROD_W + 1;
  localparam logic [5:0] QP_LAST = 6'(QP_MAX);
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] RND_TWO = EXT_W'(2);

  init_state_e r_state, w_state_next;
  logic [5:0]  r_init_cnt;
  logic        r_init_done;
  logic        w_tbl_wr;

  logic w_adv, w_accept;
  logic [5:0] w_rd_addr;
  logic [ENTRY_W-1:0] w_tbl_q;

  logic                  r_s1_valid;
  mode_e                 r_s1_mode;
  logic signed [DC_W-1:0] r_s1_dc;
  logic [16*COEFF_W-1:0] r_s1_coeff;

  logic                    r_s2_valid;
  mode_e                   r_s2_mode;
  logic signed [DC_W-1:0]  r_s2_dc;
  logic signed [PROD_W-1:0] r_s2_prod [16];
  logic signed [PROD_W-1:0] w_prod [16];

  logic               r_out_valid, r_out_sat;
  logic [16*OUT_W-1:0] r_out_coeff, w_out;
  logic               w_sat;

  // Init FSM state register and table-address counter; init_done rises
  // one cycle after the FSM reaches RUN and stays up until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_init_done <= (r_state == ST_RUN);
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 6'd1;
    end
  end

  // Write one table entry per INIT cycle; leave for RUN after the last QP.
  always_comb begin
    w_state_next = r_state;
    w_tbl_wr     = 1'b0;
    if (r_state == ST_INIT) begin
      w_tbl_wr = 1'b1;
      if (r_init_cnt == QP_LAST) w_state_next = ST_RUN;
    end
  end

  assign w_adv     = ~r_out_valid | out_ready;
  assign in_ready  = r_init_done & w_adv;
  assign w_accept  = in_valid & in_ready;
  assign w_rd_addr = (in_qp > QP_LAST) ? QP_LAST : in_qp;

  dequant_scale_table u_table (
    .clk      (clk),
    .wr       (w_tbl_wr),
    .wr_addr  (r_init_cnt),
    .rd_en    (w_accept),
    .rd_addr  (w_rd_addr),
    .data_in  (scale_entry(r_init_cnt)),
    .data_out (w_tbl_q)
  );

  // Stage 1 captures the beat alongside the table read issued this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_mode  <= mode_e'(in_mode);
        r_s1_dc    <= in_dc;
        r_s1_coeff <= in_coeff;
      end
    end
  end

  // Pick each lane's scale by position class (DC modes always use v0) and
  // form the signed product; the scale is unsigned so it gets a zero MSB.
  always_comb begin
    logic [SCALE_W-1:0] sc;
    sc = '0;
    for (int i = 0; i < 16; i++) begin
      case (lane_class(4'(i)))
        CLS_V0:  sc = w_tbl_q[SCALE_W-1:0];
        CLS_V2:  sc = w_tbl_q[3*SCALE_W-1:2*SCALE_W];
        default: sc = w_tbl_q[2*SCALE_W-1:SCALE_W];
      endcase
      if (r_s1_mode == MODE_LUMA_DC || r_s1_mode == MODE_CHROMA_DC)
        sc = w_tbl_q[SCALE_W-1:0];
      w_prod[i] = PROD_W'($signed(r_s1_coeff[i*COEFF_W +: COEFF_W])) *
                  PROD_W'($signed({1'b0, sc}));
    end
  end

  // Stage 2 product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mode <= r_s1_mode;
        r_s2_dc   <= r_s1_dc;
        r_s2_prod <= w_prod;
      end
    end
  end

  // Mode-dependent round/shift in a width that also fits the DC input,
  // then clip each lane to OUT_W and collect the clip flags.
  always_comb begin
    logic signed [EXT_W-1:0] ext, res, rnd;
    ext   = '0;
    res   = '0;
    rnd   = '0;
    w_out = '0;
    w_sat = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ext = EXT_W'(r_s2_prod[i]);
      res = ext;
      case (r_s2_mode)
        MODE_LUMA_DC: begin
          rnd = ext + RND_TWO;
          res = rnd >>> 2;
        end
        MODE_CHROMA_DC: begin
          if (i < 4) res = ext >>> 1;
          else       res = '0;
        end
        MODE_AC_DC: begin
          if (i == 0) res = EXT_W'(r_s2_dc);
        end
        default: ;
      endcase
      if (res > SAT_MAX) begin
        w_out[i*OUT_W +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
        w_sat = 1'b1;
      end else if (res < SAT_MIN) begin
        w_out[i*OUT_W +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
        w_sat = 1'b1;
      end else begin
        w_out[i*OUT_W +: OUT_W] = res[OUT_W-1:0];
      end
    end
  end

  // Output register: bubbles advance out_valid but leave the data alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_coeff <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_coeff <= w_out;
        r_out_sat   <= w_sat;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_coeff = r_out_coeff;
  assign out_sat   = r_out_sat;
  assign init_done = r_init_done;

endmodule
